// File: rtl/palabra32_a_byte8_if.sv
// Word-in / byte-out handshake bundle for palabra32_a_byte8.
// The slave modport is the serializer side; the master modport is the upstream/downstream driver side.
interface palabra32_a_byte8_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, valid_out
  );
endinterface

// File: rtl/palabra32_a_byte8.sv
// 32-bit word to 8-bit byte serializer, MSB lane first, with one-word hold buffer for gapless streaming.
// Build option: define IDLE_BYTE_EN to drive 8'hBC instead of 8'h00 on data_out while valid_out is low.
module palabra32_a_byte8 (
  input logic                 clk_4f,
  input logic                 reset_L,
  palabra32_a_byte8_if.slave  bus
);

`ifdef IDLE_BYTE_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state,     w_state;
  logic [1:0]  r_cnt,       w_cnt;
  logic [31:0] r_word,      w_word;
  logic [31:0] r_hold,      w_hold;
  logic        r_holdValid, w_holdValid;
  logic [7:0]  r_dataOut,   w_dataOut;
  logic        r_validOut,  w_validOut;
  logic        w_accept;

  // ready is a pure function of the hold flag, so it never depends on valid_in
  assign bus.ready_out = ~r_holdValid;
  assign bus.data_out  = r_dataOut;
  assign bus.valid_out = r_validOut;
  assign w_accept      = bus.valid_in & ~r_holdValid;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_word      <= 32'd0;
      r_hold      <= 32'd0;
      r_holdValid <= 1'b0;
      r_dataOut   <= IDLE_BYTE;
      r_validOut  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_word      <= w_word;
      r_hold      <= w_hold;
      r_holdValid <= w_holdValid;
      r_dataOut   <= w_dataOut;
      r_validOut  <= w_validOut;
    end
  end

  // The word register rotates left one lane per byte, so bits 23:16 always hold the next lane to emit
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_word      = r_word;
    w_hold      = r_hold;
    w_holdValid = r_holdValid;
    w_dataOut   = r_dataOut;
    w_validOut  = r_validOut;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_word     = bus.data_in;
          w_dataOut  = bus.data_in[31:24];
          w_validOut = 1'b1;
          w_cnt      = 2'd0;
          w_state    = SEND;
        end
      end

      SEND: begin
        if (r_cnt != 2'd3) begin
          w_cnt     = r_cnt + 2'd1;
          w_dataOut = r_word[23:16];
          w_word    = {r_word[23:0], r_word[31:24]};
          if (w_accept) begin
            w_hold      = bus.data_in;
            w_holdValid = 1'b1;
          end
        end else if (r_holdValid) begin
          w_word      = r_hold;
          w_dataOut   = r_hold[31:24];
          w_cnt       = 2'd0;
          w_holdValid = 1'b0;
        end else if (bus.valid_in) begin
          w_word    = bus.data_in;
          w_dataOut = bus.data_in[31:24];
          w_cnt     = 2'd0;
        end else begin
          w_state    = IDLE;
          w_cnt      = 2'd0;
          w_validOut = 1'b0;
          w_dataOut  = IDLE_BYTE;
        end
      end

      default: begin
        w_state    = IDLE;
        w_cnt      = 2'd0;
        w_validOut = 1'b0;
        w_dataOut  = IDLE_BYTE;
      end
    endcase
  end

endmodule

// File: tb/tb_palabra32_a_byte8.sv
// Self-checking bench for palabra32_a_byte8: directed vector table, reset corner sequences and a random scoreboard.
// Honours IDLE_BYTE_EN for the expected idle byte.
module tb_palabra32_a_byte8;

`ifdef IDLE_BYTE_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ev;
    logic [7:0]  eb;
    logic        er;
  } vec_t;

  logic clk;
  logic rstL;
  int   total;
  int   bad;
  vec_t vecs[$];
  logic [7:0] sb[$];

  palabra32_a_byte8_if bus();

  palabra32_a_byte8 dut (
    .clk_4f  (clk),
    .reset_L (rstL),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic v, input logic [31:0] d, input logic ev, input logic [7:0] eb, input logic er);
    vec_t x;
    x.v = v; x.d = d; x.ev = ev; x.eb = eb; x.er = er;
    vecs.push_back(x);
  endtask

  // Called 1 time unit after a rising edge: drives inputs, then advances past the next edge
  task automatic applyStimulus(input logic v, input logic [31:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [7:0] eb, input logic er);
    total++;
    if (bus.valid_out !== ev || bus.data_out !== eb || bus.ready_out !== er) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b data=%h ready=%b, want valid=%b data=%h ready=%b",
               name, bus.valid_out, bus.data_out, bus.ready_out, ev, eb, er);
    end
  endtask

  task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.valid_in = 1'b0;
    bus.data_in  = 32'd0;
    rstL = 1'b1;

    // single word, then three back-to-back words, then hold fill at cnt=1, then direct load at cnt=3
    addVec(1, 32'hA1B2C3D4, 1, 8'hA1, 1);
    addVec(0, 32'h0,        1, 8'hB2, 1);
    addVec(0, 32'h0,        1, 8'hC3, 1);
    addVec(0, 32'h0,        1, 8'hD4, 1);
    addVec(0, 32'h0,        0, IDLE_EXP, 1);
    addVec(1, 32'h01020304, 1, 8'h01, 1);
    addVec(1, 32'h05060708, 1, 8'h02, 0);
    addVec(1, 32'h090A0B0C, 1, 8'h03, 0);
    addVec(1, 32'h090A0B0C, 1, 8'h04, 0);
    addVec(1, 32'h090A0B0C, 1, 8'h05, 1);
    addVec(1, 32'h090A0B0C, 1, 8'h06, 0);
    addVec(0, 32'h0,        1, 8'h07, 0);
    addVec(0, 32'h0,        1, 8'h08, 0);
    addVec(0, 32'h0,        1, 8'h09, 1);
    addVec(0, 32'h0,        1, 8'h0A, 1);
    addVec(0, 32'h0,        1, 8'h0B, 1);
    addVec(0, 32'h0,        1, 8'h0C, 1);
    addVec(0, 32'h0,        0, IDLE_EXP, 1);
    addVec(1, 32'hCAFEF00D, 1, 8'hCA, 1);
    addVec(0, 32'h0,        1, 8'hFE, 1);
    addVec(1, 32'hDEADBEEF, 1, 8'hF0, 0);
    addVec(0, 32'h0,        1, 8'h0D, 0);
    addVec(0, 32'h0,        1, 8'hDE, 1);
    addVec(0, 32'h0,        1, 8'hAD, 1);
    addVec(0, 32'h0,        1, 8'hBE, 1);
    addVec(0, 32'h0,        1, 8'hEF, 1);
    addVec(1, 32'h11223344, 1, 8'h11, 1);
    addVec(0, 32'h0,        1, 8'h22, 1);
    addVec(0, 32'h0,        1, 8'h33, 1);
    addVec(0, 32'h0,        1, 8'h44, 1);
    addVec(0, 32'h0,        0, IDLE_EXP, 1);

    #1 rstL = 1'b0;
    #2 checkOutput("reset_before_clock", 0, IDLE_EXP, 1);
    @(posedge clk);
    #1 checkOutput("reset_held", 0, IDLE_EXP, 1);
    rstL = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].er);
    end

    // asynchronous reset right after B2: C3/D4 must never appear
    applyStimulus(1, 32'hA1B2C3D4);
    checkOutput("rst_mid_A1", 1, 8'hA1, 1);
    applyStimulus(0, 32'h0);
    checkOutput("rst_mid_B2", 1, 8'hB2, 1);
    #2 rstL = 1'b0;
    #1 checkOutput("rst_mid_async", 0, IDLE_EXP, 1);
    @(posedge clk);
    #1 checkOutput("rst_mid_held", 0, IDLE_EXP, 1);
    #2 rstL = 1'b1;
    applyStimulus(1, 32'h55667788);
    checkOutput("post_rst_55", 1, 8'h55, 1);
    applyStimulus(0, 32'h0);
    checkOutput("post_rst_66", 1, 8'h66, 1);
    applyStimulus(0, 32'h0);
    checkOutput("post_rst_77", 1, 8'h77, 1);
    applyStimulus(0, 32'h0);
    checkOutput("post_rst_88", 1, 8'h88, 1);
    applyStimulus(0, 32'h0);
    checkOutput("post_rst_idle", 0, IDLE_EXP, 1);

    // reset while the hold register is full: the held word must be discarded
    applyStimulus(1, 32'hAAAA0000);
    checkOutput("hold_rst_AA0", 1, 8'hAA, 1);
    applyStimulus(1, 32'hBBBB1111);
    checkOutput("hold_rst_AA1", 1, 8'hAA, 0);
    bus.valid_in = 1'b0;
    #2 rstL = 1'b0;
    #1 checkOutput("hold_rst_async", 0, IDLE_EXP, 1);
    rstL = 1'b1;
    @(posedge clk);
    #1 checkOutput("hold_rst_release", 0, IDLE_EXP, 1);
    applyStimulus(1, 32'h12345678);
    checkOutput("hold_rst_12", 1, 8'h12, 1);
    applyStimulus(0, 32'h0);
    checkOutput("hold_rst_34", 1, 8'h34, 1);
    applyStimulus(0, 32'h0);
    checkOutput("hold_rst_56", 1, 8'h56, 1);
    applyStimulus(0, 32'h0);
    checkOutput("hold_rst_78", 1, 8'h78, 1);
    applyStimulus(0, 32'h0);
    checkOutput("hold_rst_idle", 0, IDLE_EXP, 1);

    // random valid_in against a byte scoreboard; upstream keeps its word until accepted
    begin
      logic        pending;
      logic [31:0] word;
      int          accepted;
      int          cycles;
      pending  = 1'b0;
      word     = 32'd0;
      accepted = 0;
      cycles   = 0;
      while ((accepted < 1000 || sb.size() != 0) && cycles < 20000) begin
        if (!pending && accepted < 1000 && $urandom_range(0, 2) != 0) begin
          pending = 1'b1;
          word    = $urandom;
        end
        bus.valid_in = pending;
        bus.data_in  = word;
        if (pending && bus.ready_out) begin
          sb.push_back(word[31:24]);
          sb.push_back(word[23:16]);
          sb.push_back(word[15:8]);
          sb.push_back(word[7:0]);
          pending = 1'b0;
          accepted++;
        end
        @(posedge clk);
        #1;
        cycles++;
        if (bus.valid_out) begin
          if (sb.size() == 0) checkByte("rand_extra_byte", bus.data_out, 8'hxx);
          else checkByte("rand_byte", bus.data_out, sb.pop_front());
        end else begin
          checkByte("rand_idle", bus.data_out, IDLE_EXP);
        end
      end
      total++;
      if (accepted != 1000 || sb.size() != 0) begin
        bad++;
        $display("[TB] FAIL rand_drain: got accepted=%0d left=%0d, want accepted=1000 left=0", accepted, sb.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
